// File: rtl/rv16_fu_sched_if.sv
// Bundle of the issue, functional-unit and writeback signals of the rv16
// execute-stage scheduler. The master side is the scheduler itself; the
// slave side is everything around it (decode, MUL/DIV units, register file).
interface rv16_fu_sched_if #(
  parameter int OPC_W  = 4,
  parameter int REG_AW = 4
);
  logic              iss_valid;
  logic              iss_ready;
  logic [OPC_W-1:0]  iss_opcode;
  logic [REG_AW-1:0] iss_rd;
  logic              mul_start;
  logic              mul_done;
  logic              div_start;
  logic              div_done;
  logic [6:0]        fu_sel;
  logic              wb_valid;
  logic              wb_ready;
  logic [REG_AW-1:0] wb_rd;
  logic              illegal_op;
  logic              fu_timeout;
  logic              busy;

  modport master (
    input  iss_valid, iss_opcode, iss_rd, mul_done, div_done, wb_ready,
    output iss_ready, mul_start, div_start, fu_sel, wb_valid, wb_rd,
           illegal_op, fu_timeout, busy
  );

  modport slave (
    output iss_valid, iss_opcode, iss_rd, mul_done, div_done, wb_ready,
    input  iss_ready, mul_start, div_start, fu_sel, wb_valid, wb_rd,
           illegal_op, fu_timeout, busy
  );
endinterface

// File: rtl/rv16_fu_sched.sv
// rv16 execute-stage scheduler: accepts one decoded ALU instruction at a
// time, completes single-cycle ops directly, sequences MUL/DIV through a
// start/done handshake with timeout, drives the one-hot result-mux select
// and holds the writeback request until the register file takes it.
// Every output is a register or a decode of registered state only.
module rv16_fu_sched #(
  parameter int OPC_W   = 4,
  parameter int REG_AW  = 4,
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst_n,
  rv16_fu_sched_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_MUL = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_DIV = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_AND = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_OR  = OPC_W'(6);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_MC = 2'd1,
    WB      = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [OPC_W-1:0]  op_q;
  logic [REG_AW-1:0] rd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              mul_start_q, div_start_q;
  logic              illegal_q, timeout_q;
  logic [6:0]        fu_sel_d;

  logic accept, legal, multi_cycle, start_cycle, sel_done, done_ok, cnt_full;

  assign accept      = (state_q == IDLE) && bus.iss_valid;
  assign legal       = (bus.iss_opcode <= OP_OR);
  assign multi_cycle = (bus.iss_opcode == OP_MUL) || (bus.iss_opcode == OP_DIV);

  // The start pulse marks the first WAIT_MC cycle; a done seen there is too early.
  assign start_cycle = mul_start_q | div_start_q;
  assign sel_done    = (op_q == OP_MUL) ? bus.mul_done : bus.div_done;
  assign done_ok     = (state_q == WAIT_MC) && !start_cycle && sel_done;
  assign cnt_full    = (cnt_q == CNT_W'(TIMEOUT));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge values; blocking = here would create order-dependent races.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a done on the final counted cycle beats the timeout.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && legal) state_d = multi_cycle ? WAIT_MC : WB;
      WAIT_MC: if (done_ok)         state_d = WB;
               else if (cnt_full)   state_d = IDLE;
      WB:      if (bus.wb_ready)    state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Latched instruction, wait counter and one-cycle pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      mul_start_q <= accept && (bus.iss_opcode == OP_MUL);
      div_start_q <= accept && (bus.iss_opcode == OP_DIV);
      illegal_q   <= accept && !legal;
      timeout_q   <= (state_q == WAIT_MC) && !done_ok && cnt_full;
      if (accept) begin
        op_q  <= bus.iss_opcode;
        rd_q  <= bus.iss_rd;
        cnt_q <= '0;
      end else if (state_q == WAIT_MC && !cnt_full) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // One-hot result-mux select, only while an instruction is in flight.
  always_comb begin
    fu_sel_d = '0;
    if (state_q != IDLE) begin
      case (op_q)
        OP_ADD:  fu_sel_d = 7'b0000001;
        OP_SUB:  fu_sel_d = 7'b0000010;
        OP_MUL:  fu_sel_d = 7'b0000100;
        OP_DIV:  fu_sel_d = 7'b0001000;
        OP_XOR:  fu_sel_d = 7'b0010000;
        OP_AND:  fu_sel_d = 7'b0100000;
        OP_OR:   fu_sel_d = 7'b1000000;
        default: fu_sel_d = '0;
      endcase
    end
  end

  assign bus.iss_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.wb_valid   = (state_q == WB);
  assign bus.wb_rd      = rd_q;
  assign bus.fu_sel     = fu_sel_d;
  assign bus.mul_start  = mul_start_q;
  assign bus.div_start  = div_start_q;
  assign bus.illegal_op = illegal_q;
  assign bus.fu_timeout = timeout_q;

endmodule

// File: tb/tb_rv16_fu_sched.sv
// Bench for rv16_fu_sched: a transaction-level model (one in-flight
// instruction, its age in cycles and whether it is waiting to write back)
// predicts every output each cycle; directed sections pin the model with
// literal values, then randomized traffic runs against it.
module tb_rv16_fu_sched;

  localparam int TIMEOUT = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   started = 1'b0;

  always #5 clk = ~clk;

  rv16_fu_sched_if #(.OPC_W(4), .REG_AW(4)) bus ();

  rv16_fu_sched #(.OPC_W(4), .REG_AW(4), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_age counts edges since acceptance: 1 in the start cycle of MUL/DIV,
  // so a done is honoured when m_age>=2 and the wait has lasted m_age-1.
  bit m_active = 0, m_in_wb = 0, m_illegal = 0, m_timeout = 0;
  int m_op = 0, m_rd = 0, m_age = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_in_wb = 0; m_illegal = 0; m_timeout = 0;
      m_op = 0; m_rd = 0; m_age = 0;
    end else begin
      m_illegal = 0;
      m_timeout = 0;
      if (!m_active) begin
        if (bus.iss_valid) begin
          if (int'(bus.iss_opcode) > 6) m_illegal = 1;
          else begin
            m_active = 1;
            m_op     = int'(bus.iss_opcode);
            m_rd     = int'(bus.iss_rd);
            m_age    = 1;
            m_in_wb  = !(m_op == 2 || m_op == 3);
          end
        end
      end else if (m_in_wb) begin
        if (bus.wb_ready) begin m_active = 0; m_in_wb = 0; end
      end else begin
        if (m_age >= 2 && ((m_op == 2) ? bus.mul_done : bus.div_done)) m_in_wb = 1;
        else if (m_age - 1 == TIMEOUT) begin m_timeout = 1; m_active = 0; end
        else m_age++;
      end
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("iss_ready", bus.iss_ready, !m_active);
      check("busy", bus.busy, m_active);
      check("wb_valid", bus.wb_valid, m_in_wb);
      if (m_in_wb) check("wb_rd", bus.wb_rd, m_rd);
      check("fu_sel", bus.fu_sel, m_active ? (32'd1 << m_op) : 32'd0);
      check("mul_start", bus.mul_start, m_active && !m_in_wb && m_age == 1 && m_op == 2);
      check("div_start", bus.div_start, m_active && !m_in_wb && m_age == 1 && m_op == 3);
      check("illegal_op", bus.illegal_op, m_illegal);
      check("fu_timeout", bus.fu_timeout, m_timeout);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int opc, input int rd);
    bus.iss_valid  = 1'b1;
    bus.iss_opcode = 4'(opc);
    bus.iss_rd     = 4'(rd);
    tick();
    bus.iss_valid  = 1'b0;
  endtask

  int n_to, to_at, n_wb;

  initial begin
    rst_n = 1'b1;
    bus.iss_valid = 0; bus.iss_opcode = '0; bus.iss_rd = '0;
    bus.mul_done = 0; bus.div_done = 0; bus.wb_ready = 1;
    #2 rst_n = 1'b0;
    started = 1'b1;
    @(negedge clk);
    check("rst_iss_ready", bus.iss_ready, 1);
    check("rst_busy", bus.busy, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // ADD rd=5, writeback taken at once.
    issue(0, 5);                                   // now cycle N+1
    @(negedge clk);
    check("add_wb_valid", bus.wb_valid, 1);
    check("add_wb_rd", bus.wb_rd, 5);
    check("add_fu_sel", bus.fu_sel, 7'b0000001);
    tick();                                        // N+2
    @(negedge clk);
    check("add_ready_again", bus.iss_ready, 1);
    tick();

    // MUL rd=3, done at N+4, regfile stalls 3 cycles.
    bus.wb_ready = 0;
    issue(2, 3);                                   // N+1
    @(negedge clk);
    check("mul_start_n1", bus.mul_start, 1);
    check("mul_fu_sel_n1", bus.fu_sel, 7'b0000100);
    tick(); tick(); tick();                        // N+4
    bus.mul_done = 1;
    tick();                                        // N+5
    bus.mul_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mul_wb_hold_valid", bus.wb_valid, 1);
      check("mul_wb_hold_rd", bus.wb_rd, 3);
      check("mul_wb_hold_sel", bus.fu_sel, 7'b0000100);
      tick();
    end
    bus.wb_ready = 1;
    tick();
    @(negedge clk);
    check("mul_done_idle", bus.iss_ready, 1);
    tick();

    // DIV with no done: exactly one timeout pulse, no writeback.
    issue(3, 7);
    n_to = 0; to_at = 0; n_wb = 0;
    for (int i = 1; i <= TIMEOUT + 6; i++) begin
      @(negedge clk);
      if (bus.fu_timeout) begin n_to++; to_at = i; end
      if (bus.wb_valid) n_wb++;
      tick();
    end
    check("to_pulses", n_to, 1);
    check("to_cycle", to_at, TIMEOUT + 2);
    check("to_no_wb", n_wb, 0);
    check("to_idle", bus.busy, 0);

    // DIV with done on the very cycle the counter reaches TIMEOUT.
    issue(3, 9);                                   // N+1
    n_to = 0;
    for (int i = 1; i <= TIMEOUT + 3; i++) begin
      bus.div_done = (i == TIMEOUT + 1);
      @(negedge clk);
      if (bus.fu_timeout) n_to++;
      if (i == TIMEOUT + 2) begin
        check("late_done_wb", bus.wb_valid, 1);
        check("late_done_rd", bus.wb_rd, 9);
      end
      tick();
    end
    bus.div_done = 0;
    check("late_done_no_to", n_to, 0);

    // Illegal opcode 1001, then OR rd=15.
    issue(9, 2);                                   // N+1
    @(negedge clk);
    check("ill_pulse", bus.illegal_op, 1);
    check("ill_busy", bus.busy, 0);
    check("ill_no_wb", bus.wb_valid, 0);
    tick();
    @(negedge clk);
    check("ill_pulse_end", bus.illegal_op, 0);
    tick();
    issue(6, 15);
    @(negedge clk);
    check("or_fu_sel", bus.fu_sel, 7'b1000000);
    check("or_wb_rd", bus.wb_rd, 15);
    tick(); tick();

    // DIV with stray dones: both in start cycle, then a mul_done, then a real div_done.
    issue(3, 4);                                   // N+1 start cycle
    bus.mul_done = 1; bus.div_done = 1;
    tick();                                        // N+2
    bus.mul_done = 0; bus.div_done = 0;
    @(negedge clk);
    check("stray_start_ignored", bus.wb_valid, 0);
    check("stray_busy", bus.busy, 1);
    tick();                                        // N+3
    bus.mul_done = 1;
    tick();                                        // N+4
    bus.mul_done = 0;
    @(negedge clk);
    check("stray_mul_ignored", bus.wb_valid, 0);
    tick();                                        // N+5
    bus.div_done = 1;
    tick();                                        // N+6
    bus.div_done = 0;
    @(negedge clk);
    check("stray_div_wb", bus.wb_valid, 1);
    check("stray_div_rd", bus.wb_rd, 4);
    tick(); tick();

    // Reset in the middle of a stalled writeback.
    bus.wb_ready = 0;
    issue(4, 11);
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_wb_valid", bus.wb_valid, 0);
    check("rst_mid_fu_sel", bus.fu_sel, 0);
    check("rst_mid_ready", bus.iss_ready, 1);
    tick();
    rst_n = 1'b1;
    bus.wb_ready = 1;
    tick();
    bus.mul_done = 1;
    tick();
    bus.mul_done = 0;
    n_wb = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.wb_valid) n_wb++;
      tick();
    end
    check("rst_late_done_no_wb", n_wb, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bus.iss_valid  = ($urandom_range(0, 3) != 0);
      bus.iss_opcode = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 6))
                                                   : 4'($urandom_range(7, 15));
      bus.iss_rd     = 4'($urandom_range(0, 15));
      bus.mul_done   = ($urandom_range(0, 19) == 0);
      bus.div_done   = ($urandom_range(0, 19) == 0);
      bus.wb_ready   = ($urandom_range(0, 2) != 0);
      tick();
    end
    bus.iss_valid = 0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
